// File: rtl/crossing_pkg.sv
// Shared types and constants for the two-track level-crossing sequencer.
package crossing_pkg;

   localparam int NUM_TRACKS = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WARN,
      ST_LOWERING,
      ST_DOWN,
      ST_HOLD,
      ST_RAISING
   } state_t;

   function automatic int cnt_width(input int max_trains);
      return $clog2(max_trains + 1);
   endfunction

endpackage

// File: rtl/track_occupancy.sv
// Per-track sensor edge detection and saturating train counter.
// Optional CROSSING_FAULT_EN reports counter over/underflow attempts on fault_set.
module track_occupancy
   import crossing_pkg::*;
#(
   parameter int MAX_TRAINS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic approach,
   input  logic exit,
   output logic apr_edge,
   output logic occ_next,
   output logic occupied,
   output logic fault_set
);

   localparam int CW = cnt_width(MAX_TRAINS);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_TRAINS);

   logic          apr_prev_q;
   logic          ext_prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          occ_q;
   logic          ext_edge;
   logic          at_max;
   logic          at_zero;

   assign apr_edge = approach & ~apr_prev_q;
   assign ext_edge = exit & ~ext_prev_q;
   assign at_max   = (cnt_q == CNT_MAX);
   assign at_zero  = (cnt_q == '0);

   // Simultaneous entry and exit on one track cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (apr_edge && !ext_edge && !at_max) begin
         cnt_d = cnt_q + CW'(1);
      end else if (ext_edge && !apr_edge && !at_zero) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   assign occ_next = (cnt_d != '0);
   assign occupied = occ_q;

`ifdef CROSSING_FAULT_EN
   assign fault_set = (apr_edge & ~ext_edge & at_max) | (ext_edge & ~apr_edge & at_zero);
`else
   assign fault_set = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         apr_prev_q <= 1'b0;
         ext_prev_q <= 1'b0;
         cnt_q      <= '0;
         occ_q      <= 1'b0;
      end else begin
         apr_prev_q <= approach;
         ext_prev_q <= exit;
         cnt_q      <= cnt_d;
         occ_q      <= occ_next;
      end
   end

endmodule

// File: rtl/crossing_sequencer.sv
// Level-crossing gate/warning sequencer for two tracks sharing one gate.
// With CROSSING_FAULT_EN a sticky sensor fault holds the gate down until reset.
module crossing_sequencer
   import crossing_pkg::*;
#(
   parameter int WARN_CYCLES  = 8,
   parameter int GATE_CYCLES  = 4,
   parameter int CLEAR_CYCLES = 6,
   parameter int MAX_TRAINS   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_TRACKS-1:0] approach,
   input  logic [NUM_TRACKS-1:0] exit,
   output logic                  gate,
   output logic                  signal,
   output logic                  gate_closed,
   output logic [NUM_TRACKS-1:0] occupied,
   output logic                  fault
);

   localparam int WG_MAX  = (WARN_CYCLES > GATE_CYCLES) ? WARN_CYCLES : GATE_CYCLES;
   localparam int TMR_MAX = (WG_MAX > CLEAR_CYCLES) ? WG_MAX : CLEAR_CYCLES;
   localparam int TW      = $clog2(TMR_MAX + 1);

   state_t                state_q, state_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  gate_q, gate_d;
   logic                  signal_q, signal_d;
   logic                  closed_q, closed_d;
   logic                  fault_q, fault_d;
   logic [NUM_TRACKS-1:0] apr_edge;
   logic [NUM_TRACKS-1:0] occ_next;
   logic [NUM_TRACKS-1:0] fault_set;
   logic                  any_occ;
   logic                  timer_done;
   logic                  trig;

   for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
      track_occupancy #(
         .MAX_TRAINS(MAX_TRAINS)
      ) u_trk (
         .clk      (clk),
         .reset    (reset),
         .approach (approach[t]),
         .exit     (exit[t]),
         .apr_edge (apr_edge[t]),
         .occ_next (occ_next[t]),
         .occupied (occupied[t]),
         .fault_set(fault_set[t])
      );
   end

   assign any_occ    = |occ_next;
   assign timer_done = (timer_q == TW'(1));
   assign fault_d    = fault_q | (|fault_set);
   // A fault behaves like a fresh approach so every state heads for DOWN.
   assign trig       = (|apr_edge) | fault_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         timer_q  <= '0;
         gate_q   <= 1'b0;
         signal_q <= 1'b0;
         closed_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         gate_q   <= gate_d;
         signal_q <= signal_d;
         closed_q <= closed_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = (timer_q != '0) ? timer_q - TW'(1) : '0;
      unique case (state_q)
         ST_IDLE: begin
            if (trig) begin
               state_d = ST_WARN;
               timer_d = TW'(WARN_CYCLES);
            end
         end
         ST_WARN: begin
            if (timer_done) begin
               state_d = ST_LOWERING;
               timer_d = TW'(GATE_CYCLES);
            end
         end
         ST_LOWERING: begin
            if (timer_done) state_d = ST_DOWN;
         end
         ST_DOWN: begin
            if (!any_occ && !fault_d) begin
               state_d = ST_HOLD;
               timer_d = TW'(CLEAR_CYCLES);
            end
         end
         ST_HOLD: begin
            if (trig) begin
               state_d = ST_DOWN;
            end else if (timer_done) begin
               state_d = ST_RAISING;
               timer_d = TW'(GATE_CYCLES);
            end
         end
         ST_RAISING: begin
            if (trig) begin
               state_d = ST_LOWERING;
               timer_d = TW'(GATE_CYCLES);
            end else if (timer_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      signal_d = (state_d != ST_IDLE);
      gate_d   = (state_d == ST_LOWERING) || (state_d == ST_DOWN) || (state_d == ST_HOLD);
      closed_d = (state_d == ST_DOWN) || (state_d == ST_HOLD);
   end

   assign gate        = gate_q;
   assign signal      = signal_q;
   assign gate_closed = closed_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Scoreboard bench for crossing_sequencer; fault expectations follow CROSSING_FAULT_EN.
module tb_crossing_sequencer;

   localparam int WARN  = 8;
   localparam int GATE  = 4;
   localparam int CLEAR = 6;
   localparam int MAXT  = 3;

   localparam int S_IDLE = 0, S_WARN = 1, S_LOW = 2, S_DOWN = 3, S_HOLD = 4, S_RAISE = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] approach = 2'b00;
   logic [1:0] exit_s = 2'b00;
   logic       gate, signal, gate_closed, fault;
   logic [1:0] occupied;

   crossing_sequencer #(
      .WARN_CYCLES (WARN),
      .GATE_CYCLES (GATE),
      .CLEAR_CYCLES(CLEAR),
      .MAX_TRAINS  (MAXT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .approach   (approach),
      .exit       (exit_s),
      .gate       (gate),
      .signal     (signal),
      .gate_closed(gate_closed),
      .occupied   (occupied),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;
   int         m_state;
   int         m_cnt [2];
   int         m_dl;
   int         m_sat = 0;
   logic [1:0] m_pa, m_pe;
   logic       m_fault;
   logic [5:0] sb_q [$];
   int         lr [4];
   int         lf [4];
   int         nf [4];
   logic [3:0] prev_obs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
      end
   endtask

   // Cycle-level reference: timed states tracked as absolute deadline cycles.
   task automatic model_edge(input logic rn, input logic [1:0] a, input logic [1:0] e);
      logic [1:0] ae, ee;
      logic       fset, any, trig;
      if (!rn) begin
         m_state = S_IDLE; m_cnt[0] = 0; m_cnt[1] = 0; m_pa = 0; m_pe = 0;
         m_dl = 0; m_fault = 0;
      end else begin
         ae = a & ~m_pa;
         ee = e & ~m_pe;
         m_pa = a;
         m_pe = e;
         fset = 0;
         for (int t = 0; t < 2; t++) begin
            if (ae[t] && !ee[t]) begin
               if (m_cnt[t] == MAXT) fset = 1; else m_cnt[t]++;
            end else if (ee[t] && !ae[t]) begin
               if (m_cnt[t] == 0) fset = 1; else m_cnt[t]--;
            end
         end
         if (fset) m_sat++;
`ifdef CROSSING_FAULT_EN
         m_fault = m_fault | fset;
`endif
         any  = (m_cnt[0] != 0) || (m_cnt[1] != 0);
         trig = (ae != 2'b00) || m_fault;
         case (m_state)
            S_IDLE:  if (trig) begin m_state = S_WARN; m_dl = cyc + WARN; end
            S_WARN:  if (cyc == m_dl) begin m_state = S_LOW; m_dl = cyc + GATE; end
            S_LOW:   if (cyc == m_dl) m_state = S_DOWN;
            S_DOWN:  if (!any && !m_fault) begin m_state = S_HOLD; m_dl = cyc + CLEAR; end
            S_HOLD: begin
               if (trig) m_state = S_DOWN;
               else if (cyc == m_dl) begin m_state = S_RAISE; m_dl = cyc + GATE; end
            end
            S_RAISE: begin
               if (trig) begin m_state = S_LOW; m_dl = cyc + GATE; end
               else if (cyc == m_dl) m_state = S_IDLE;
            end
            default: m_state = S_IDLE;
         endcase
      end
   endtask

   function automatic logic [5:0] model_out();
      logic g, s, c;
      g = (m_state == S_LOW) || (m_state == S_DOWN) || (m_state == S_HOLD);
      s = (m_state != S_IDLE);
      c = (m_state == S_DOWN) || (m_state == S_HOLD);
      return {m_fault, m_cnt[1] != 0, m_cnt[0] != 0, c, s, g};
   endfunction

   task automatic step(input logic rn, input logic [1:0] a, input logic [1:0] e);
      logic [5:0] obs, exp;
      reset = rn;
      approach = a;
      exit_s = e;
      cyc++;
      model_edge(rn, a, e);
      sb_q.push_back(model_out());
      @(posedge clk);
      @(negedge clk);
      exp = sb_q.pop_front();
      obs = {fault, occupied, gate_closed, signal, gate};
      chk("outputs", 32'(obs), 32'(exp));
      for (int k = 0; k < 4; k++) begin
         if (obs[k] && !prev_obs[k]) lr[k] = cyc;
         if (!obs[k] && prev_obs[k]) begin lf[k] = cyc; nf[k]++; end
      end
      prev_obs = obs[3:0];
   endtask

   task automatic run_until(input int last);
      while (cyc < last) step(1'b1, 2'b00, 2'b00);
   endtask

   task automatic at(input int c, input logic [1:0] a, input logic [1:0] e);
      run_until(c - 1);
      step(1'b1, a, e);
   endtask

   task automatic new_scenario();
      cyc = 0;
      for (int k = 0; k < 4; k++) begin lr[k] = -1; lf[k] = -1; nf[k] = 0; end
      step(1'b0, 2'b00, 2'b00);
      step(1'b0, 2'b00, 2'b00);
      chk("reset_state", 32'({fault, occupied, gate_closed, signal, gate}), 32'd0);
      prev_obs = 4'b0000;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single train
      new_scenario();
      at(3, 2'b01, 2'b00);
      at(4, 2'b01, 2'b00);
      at(30, 2'b00, 2'b01);
      run_until(45);
      chk("single_signal_on", 32'(lr[1]), 32'd3);
      chk("single_gate_on", 32'(lr[0]), 32'd11);
      chk("single_closed_on", 32'(lr[2]), 32'd15);
      chk("single_gate_off", 32'(lf[0]), 32'd36);
      chk("single_signal_off", 32'(lf[1]), 32'd40);

      // Two tracks overlapping
      new_scenario();
      at(3, 2'b01, 2'b00);
      at(20, 2'b10, 2'b00);
      at(25, 2'b00, 2'b01);
      at(40, 2'b00, 2'b10);
      run_until(55);
      chk("overlap_gate_off", 32'(lf[0]), 32'd46);
      chk("overlap_gate_falls", 32'(nf[0]), 32'd1);

      // Re-entry while raising
      new_scenario();
      at(3, 2'b01, 2'b00);
      at(30, 2'b00, 2'b01);
      at(38, 2'b10, 2'b00);
      run_until(45);
      chk("reraise_gate_on", 32'(lr[0]), 32'd38);
      chk("reraise_closed_on", 32'(lr[2]), 32'd42);
      chk("reraise_signal_kept", 32'(nf[1]), 32'd0);
      at(50, 2'b00, 2'b10);
      run_until(62);
      chk("reraise_signal_off", 32'(lf[1]), 32'd60);

      // Re-entry during HOLD
      new_scenario();
      at(3, 2'b01, 2'b00);
      at(30, 2'b00, 2'b01);
      at(33, 2'b01, 2'b00);
      run_until(45);
      chk("rehold_gate_kept", 32'(nf[0]), 32'd0);
      at(46, 2'b00, 2'b01);
      run_until(55);
      chk("rehold_gate_off", 32'(lf[0]), 32'd52);

      // Held approach sensor counts once
      new_scenario();
      for (int c = 3; c <= 52; c++) step(1'b1, 2'b01, 2'b00);
      at(53, 2'b00, 2'b01);
      run_until(70);
      chk("held_occ_on", 32'(lr[3]), 32'd3);
      chk("held_occ_off", 32'(lf[3]), 32'd53);
      chk("held_occ_falls", 32'(nf[3]), 32'd1);

      // Saturation, simultaneous edges, exit at zero
      new_scenario();
      at(3, 2'b01, 2'b00);
      at(5, 2'b01, 2'b00);
      at(7, 2'b01, 2'b00);
      at(9, 2'b01, 2'b00);
      at(11, 2'b01, 2'b01);
      at(13, 2'b00, 2'b01);
      at(15, 2'b00, 2'b01);
      at(17, 2'b00, 2'b01);
      at(19, 2'b00, 2'b01);
      at(21, 2'b10, 2'b10);
      run_until(40);
      chk("sat_occ_off", 32'(lf[3]), 32'd17);

      // Reset mid-sequence
      new_scenario();
      at(3, 2'b11, 2'b00);
      run_until(20);
      step(1'b0, 2'b00, 2'b00);
      chk("reset_mid", 32'({fault, occupied, gate_closed, signal, gate}), 32'd0);
      run_until(25);

`ifdef CROSSING_FAULT_EN
      // Exit with nothing on the track latches the fault and closes the gate
      new_scenario();
      at(3, 2'b00, 2'b10);
      run_until(60);
      chk("fault_set", 32'(fault), 32'd1);
      chk("fault_closed", 32'(gate_closed), 32'd1);
      step(1'b0, 2'b00, 2'b00);
      chk("fault_cleared", 32'(fault), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
